// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding, branch-target
// table contents and an index-width helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_e;

  // Number of entries the table below defines; deeper LUTs read 0 beyond it.
  localparam int unsigned TABLE_ENTRIES = 16;

  // Width of a LUT index, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? 32'($clog2(depth)) : 32'd1;
  endfunction

  // Branch-target table; entries are truncated to PC_WIDTH by the ROM.
  function automatic int unsigned branch_target(input int unsigned idx);
    case (idx)
      32'd0:   return 32'd0;
      32'd1:   return 32'd9;
      32'd2:   return 32'd5;
      32'd3:   return 32'd40;
      32'd4:   return 32'd11;
      32'd5:   return 32'd19;
      32'd6:   return 32'd100;
      32'd7:   return 32'd200;
      32'd8:   return 32'd300;
      32'd9:   return 32'd400;
      32'd10:  return 32'd500;
      32'd11:  return 32'd600;
      32'd12:  return 32'd700;
      32'd13:  return 32'd800;
      32'd14:  return 32'd900;
      32'd15:  return 32'd1000;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit control/address bundle.
//   slave  (fetch unit): receives start, jump_flag, jump_idx, halt_req, stall;
//                        drives pc, fetch_valid, done.
//   master (core side) : the mirror image.
interface fetch_unit_if #(
  parameter int unsigned PC_WIDTH  = 10,
  parameter int unsigned LUT_DEPTH = 16
) ();
  import fetch_unit_pkg::*;

  localparam int unsigned IDX_W = idx_width(LUT_DEPTH);

  logic                 start;
  logic                 jump_flag;
  logic [IDX_W-1:0]     jump_idx;
  logic                 halt_req;
  logic                 stall;
  logic [PC_WIDTH-1:0]  pc;
  logic                 fetch_valid;
  logic                 done;

  modport master (
    output start, jump_flag, jump_idx, halt_req, stall,
    input  pc, fetch_valid, done
  );

  modport slave (
    input  start, jump_flag, jump_idx, halt_req, stall,
    output pc, fetch_valid, done
  );

endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target ROM (combinational).
//   idx_i    : LUT index
//   target_o : branch target pc; 0 for an index at or beyond LUT_DEPTH
module branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 10,
  parameter int unsigned LUT_DEPTH = 16
) (
  input  logic [idx_width(LUT_DEPTH)-1:0] idx_i,
  output logic [PC_WIDTH-1:0]             target_o
);

  always_comb begin
    target_o = '0;
    if (32'(idx_i) < LUT_DEPTH) begin
      target_o = PC_WIDTH'(branch_target(32'(idx_i)));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: state register, pc register and next-pc mux.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fetch_unit_if.slave (start, jump_flag, jump_idx, halt_req, stall
//           in; pc, fetch_valid, done out)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 10,
  parameter int unsigned LUT_DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  lut_target;

  branch_lut #(
    .PC_WIDTH  (PC_WIDTH),
    .LUT_DEPTH (LUT_DEPTH)
  ) u_branch_lut (
    .idx_i    (bus.jump_idx),
    .target_o (lut_target)
  );

  // Next-state / next-pc selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        // A taken branch wins over both stall and halt.
        if (bus.jump_flag) begin
          pc_d    = lut_target;
          state_d = FLUSH;
        end else if (!bus.stall) begin
          if (bus.halt_req) state_d = HALT;
          else              pc_d    = pc_q + PC_WIDTH'(1);
        end
      end
      FLUSH: begin
        // Squash slot lasts one cycle whether or not downstream stalls.
        state_d = RUN;
        if (!bus.stall) pc_d = pc_q + PC_WIDTH'(1);
      end
      HALT: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // State and pc registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs are the pc register and a decode of the state register.
  assign bus.pc          = pc_q;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.done        = (state_q == HALT);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10, program counter width in bits.
REQ-002 SHALL have parameter LUT_DEPTH, default 16, number of branch-target LUT entries.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins program execution from PC 0.
REQ-006 SHALL have port jump_flag  input  1  registered taken-branch flag from the ALU, valid one cycle after the BLQZ instruction executes.
REQ-007 SHALL have port jump_idx  input  $clog2(LUT_DEPTH)  branch-target LUT index, valid in the same cycle as jump_flag.
REQ-008 SHALL have port halt_req  input  1  decoder flag: the instruction at pc is a halt.
REQ-009 SHALL have port stall  input  1  hold the current pc (downstream not ready).
REQ-010 SHALL have port pc  output  PC_WIDTH  instruction memory address.
REQ-011 SHALL have port fetch_valid  output  1  the instruction at pc is to be executed.
REQ-012 SHALL have port done  output  1  program has halted; level, held until next start.

Function
REQ-013 SHALL implement the states IDLE, RUN, FLUSH and HALT.
REQ-014 IDLE: pc=0, fetch_valid=0; start -> RUN on the next edge, pc stays 0, done cleared.
REQ-015 RUN: fetch_valid=1; each edge with no event: pc <= pc+1.
REQ-016 RUN, stall=1 and no jump_flag: pc, state and fetch_valid held.
REQ-017 RUN, jump_flag=1: pc <= LUT[jump_idx], next state FLUSH; jump overrides stall and halt_req.
REQ-018 FLUSH: fetch_valid=0 for exactly one cycle (squashes the instruction fetched behind the branch); pc <= pc+1 unless stall; then RUN.
REQ-019 RUN, halt_req=1, no jump_flag, no stall: next state HALT, pc held, fetch_valid=0.
REQ-020 HALT: done=1, pc frozen; start -> RUN with pc=0 and done=0 on the next edge.
REQ-021 start SHALL be ignored in RUN and FLUSH.
REQ-022 jump_flag in IDLE, FLUSH or HALT SHALL be ignored.
REQ-023 pc increment SHALL wrap from 2^PC_WIDTH-1 to 0 with no flag.
REQ-024 jump_idx >= LUT_DEPTH SHALL yield target 0.
REQ-025 All outputs SHALL be driven from registers or state decode only (no combinational path from inputs).

Reset
REQ-026 reset SHALL, asynchronously, force state IDLE, pc=0, fetch_valid=0, done=0.
REQ-027 Reset asserted mid-RUN or mid-FLUSH SHALL discard any pending jump; after release, behaviour is as from power-up.

Structure
REQ-028 The state enum (IDLE, RUN, FLUSH, HALT) and the branch-target table contents SHALL live in the shared definitions package.
REQ-029 The target table SHALL be a sub-module branch_lut: combinational ROM, input index, output PC_WIDTH target.
REQ-030 fetch_unit SHALL contain the state register, pc register and next-pc mux only.

Verification
REQ-031 reset, start, 5 idle cycles -> pc 0,1,2,3,4,5; fetch_valid=1 from the first RUN cycle.
REQ-032 pc=7, jump_flag=1, jump_idx=3, LUT[3]=40 -> next pc=40, fetch_valid=0 one cycle, then pc=41 with fetch_valid=1.
REQ-033 pc=12, stall=1 for 3 cycles -> pc stays 12; jump_flag during stall (idx 2, LUT[2]=5) -> pc=5, state FLUSH.
REQ-034 halt_req at pc=20 -> done=1, pc frozen at 20 for 10 cycles; start -> pc=0, done=0, RUN.
REQ-035 PC_WIDTH=4, run from 0 -> pc sequence 14,15,0,1; halt_req and jump_flag together (idx 1, LUT[1]=9) -> pc=9, no HALT.
REQ-036 reset pulse mid-FLUSH -> pc=0, fetch_valid=0, done=0 immediately; start -> normal run from 0.
